fifo_v2: RTL and testbench
==========================

FIFO_V2 -- requirements
Module: fifo_v2

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 128, word capacity; power of two, >=2.
REQ-003 SHALL have parameter FWFT, default 0; 0 = standard read (1-cycle latency), 1 = first-word-fall-through.
REQ-004 SHALL have parameter AFULL_TH, default DEPTH-4, almost_full threshold (1..DEPTH-1).
REQ-005 SHALL have parameter AEMPTY_TH, default 4, almost_empty threshold (1..DEPTH-1).
REQ-006 SHALL have ports, in this order:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous active-low reset
- we  in  1  write request
- re  in  1  read request
- clear  in  1  synchronous flush
- data_in  in  WIDTH  write data
- data_out  out  WIDTH  read data
- full  out  1  count==DEPTH
- empty  out  1  count==0
- almost_full  out  1  count>=AFULL_TH
- almost_empty  out  1  count<=AEMPTY_TH
- count  out  $clog2(DEPTH)+1  words stored
- overflow  out  1  sticky: write attempted while full and not accepted
- underflow  out  1  sticky: read attempted while empty

Function
REQ-007 SHALL use one clock, clk; reset is synchronous and active-low on rst; all state updates occur on the rising edge of clk.
REQ-008 SHALL accept a write when we=1 and (full=0 or an accepted read occurs the same cycle); data_in is stored at wr_ptr and wr_ptr increments modulo DEPTH.
REQ-009 SHALL accept a read when re=1 and empty=0; rd_ptr increments modulo DEPTH.
REQ-010 SHALL never accept a read when empty=1, even with a simultaneous write; underflow is set.
REQ-011 SHALL, with full=1 and we=1 and re=1, accept both; count stays DEPTH; overflow is not set.
REQ-012 SHALL, with full=1, we=1 and re=0, drop the write, leave memory and pointers unchanged, and set overflow.
REQ-013 SHALL update count as count + accepted_write - accepted_read, never outside 0..DEPTH.
REQ-014 SHALL derive full, empty, almost_full and almost_empty combinationally from the registered count, so each reflects the count after the last edge.
REQ-015 SHALL, when FWFT=0, load data_out with the head word on the edge that accepts a read and hold data_out otherwise.
REQ-016 SHALL, when FWFT=1, drive data_out combinationally with the word at rd_ptr when empty=0 and with zero when empty=1; an accepted read advances to the next word visible after the edge.
REQ-017 SHALL, when FWFT=1, show a word written into an empty FIFO on data_out in the cycle after the write edge.
REQ-018 SHALL give clear=1 priority over we and re: rd_ptr, wr_ptr and count become 0, overflow and underflow become 0, and no read or write is accepted that cycle.
REQ-019 SHALL leave data_out held on clear when FWFT=0; memory contents need not be cleared.
REQ-020 SHALL wrap both pointers from DEPTH-1 to 0 with no loss or duplication of data.

Reset
REQ-021 SHALL, on rst=0 at a clock edge, set rd_ptr=0, wr_ptr=0, count=0, overflow=0, underflow=0 and data_out=0, overriding clear, we and re.
REQ-022 SHALL, after reset, present empty=1, full=0, almost_empty=1 and almost_full=0.
REQ-023 SHALL abandon FIFO contents when reset is asserted mid-operation; memory array contents need no reset.

Structure
REQ-024 SHALL place the count-width helper (clog2(DEPTH)+1) and the FWFT mode constants in shared package fifo_pkg.
REQ-025 SHALL instantiate one sub-module, fifo_ram: a DEPTH x WIDTH simple-dual-port array with synchronous write and asynchronous read, no reset.
REQ-026 SHALL check parameter legality at elaboration: DEPTH power of two; thresholds in range.

Verification
REQ-027 Reset with WIDTH=16, DEPTH=8: write 8 words 0x0001..0x0008 -> full=1 and count=8 after the 8th edge; almost_full rises at count=4 (AFULL_TH=4); a 9th write sets overflow=1 and count stays 8.
REQ-028 Read 8 words back with FWFT=0 -> data_out=0x0001..0x0008, each one cycle after its re edge; empty=1 after the 8th read; a further re sets underflow=1.
REQ-029 Run 20 writes and 20 reads interleaved at count 3..6 -> pointer wrap occurs twice; output order matches input order exactly.
REQ-030 With full, assert we=1 and re=1 with data_in=0xAAAA -> count stays 8, overflow=0, and 0xAAAA is read out 8 reads later.
REQ-031 With FWFT=1 and empty, write 0x1234 -> data_out=0x1234 and empty=0 the next cycle with no re; apply re -> data_out=0 and empty=1.
REQ-032 With count=5, pulse clear together with we=1 -> count=0, empty=1, overflow and underflow cleared; then assert rst=0 mid-stream -> all outputs return to their reset values on that edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants for the fifo_v2 block: read-mode selectors and count width helper.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package fifo_pkg;

   // Read-mode selectors for the FWFT parameter.
   localparam int FWFT_OFF = 0;   // registered read, data one cycle after the accepting edge
   localparam int FWFT_ON  = 1;   // head word visible combinationally

   // Count must represent 0..DEPTH inclusive, hence one bit more than the address.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH simple-dual-port storage for fifo_v2; no reset on the array.
// Latency: write lands on the clock edge; read port is asynchronous (zero cycles).
// Backpressure: none; the caller only asserts we for accepted writes.
// Ports: clk, we/waddr/wdata (write port), raddr/rdata (read port).
module fifo_ram #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 128,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_v2.sv
// Synchronous single-clock FIFO with status flags, sticky error flags and selectable FWFT read.
// Latency: FWFT=0 data_out one cycle after the read edge; FWFT=1 head visible the cycle after the write edge.
// Backpressure: writes dropped when full (unless a read frees a slot that cycle); reads ignored when empty.
// Ports: clk, rst (sync, active-low), we/re/clear requests, data_in/data_out,
//        full/empty/almost_full/almost_empty/count status, overflow/underflow sticky errors.
module fifo_v2
   import fifo_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int DEPTH     = 128,
   parameter int FWFT      = 0,
   parameter int AFULL_TH  = DEPTH - 4,
   parameter int AEMPTY_TH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic                     re,
   input  logic                     clear,
   input  logic [WIDTH-1:0]         data_in,
   output logic [WIDTH-1:0]         data_out,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [cnt_w(DEPTH)-1:0]  count,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
   localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

   // Elaboration-time legality checks.
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("fifo_v2: DEPTH must be a power of two >= 2");
   end
   if (AFULL_TH < 1 || AFULL_TH > DEPTH - 1) begin : g_bad_afull
      $error("fifo_v2: AFULL_TH out of range 1..DEPTH-1");
   end
   if (AEMPTY_TH < 1 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
      $error("fifo_v2: AEMPTY_TH out of range 1..DEPTH-1");
   end
   if (WIDTH < 1) begin : g_bad_width
      $error("fifo_v2: WIDTH must be >= 1");
   end
   if (FWFT != FWFT_OFF && FWFT != FWFT_ON) begin : g_bad_fwft
      $error("fifo_v2: FWFT must be 0 or 1");
   end

   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [CW-1:0]    count_q;
   logic             overflow_q;
   logic             underflow_q;
   logic             rd_ok;
   logic             wr_ok;
   logic [WIDTH-1:0] ram_rdata;

   assign full         = (count_q == DEPTH_C);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= AFULL_C);
   assign almost_empty = (count_q <= AEMPTY_C);
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   // A read never rides on a same-cycle write into an empty FIFO; a write
   // into a full FIFO is only legal because a read frees a slot.
   assign rd_ok = re && !empty && !clear;
   assign wr_ok = we && !clear && (!full || rd_ok);

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (clear) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         // Pointers wrap naturally because DEPTH is a power of two.
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
         count_q <= count_q + CW'(wr_ok) - CW'(rd_ok);
         if (we && !wr_ok) overflow_q  <= 1'b1;
         if (re && empty)  underflow_q <= 1'b1;
      end
   end

   fifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (wr_ok),
      .waddr (wr_ptr),
      .wdata (data_in),
      .raddr (rd_ptr),
      .rdata (ram_rdata)
   );

   if (FWFT == FWFT_ON) begin : g_fwft
      assign data_out = empty ? '0 : ram_rdata;
   end else begin : g_std
      logic [WIDTH-1:0] dout_q;

      // Held across clear; only reset or an accepted read changes it.
      always_ff @(posedge clk) begin
         if (!rst) begin
            dout_q <= '0;
         end else if (rd_ok) begin
            dout_q <= ram_rdata;
         end
      end

      assign data_out = dout_q;
   end

endmodule

// File: tb/tb_fifo_v2.sv
module tb_fifo_v2;

   localparam int W  = 16;
   localparam int D  = 8;
   localparam int CW = $clog2(D) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          we;
   logic          re;
   logic          clear;
   logic [W-1:0]  data_in;

   logic [W-1:0]  s_dout,  f_dout;
   logic          s_full,  f_full;
   logic          s_empty, f_empty;
   logic          s_af,    f_af;
   logic          s_ae,    f_ae;
   logic [CW-1:0] s_cnt,   f_cnt;
   logic          s_ov,    f_ov;
   logic          s_un,    f_un;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] sb[$];
   logic [W-1:0] exp_w;

   always #5 clk = ~clk;

   fifo_v2 #(.WIDTH(W), .DEPTH(D), .FWFT(0), .AFULL_TH(4), .AEMPTY_TH(4)) u_std (
      .clk(clk), .rst(rst), .we(we), .re(re), .clear(clear), .data_in(data_in),
      .data_out(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af),
      .almost_empty(s_ae), .count(s_cnt), .overflow(s_ov), .underflow(s_un));

   fifo_v2 #(.WIDTH(W), .DEPTH(D), .FWFT(1), .AFULL_TH(4), .AEMPTY_TH(4)) u_fwft (
      .clk(clk), .rst(rst), .we(we), .re(re), .clear(clear), .data_in(data_in),
      .data_out(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
      .almost_empty(f_ae), .count(f_cnt), .overflow(f_ov), .underflow(f_un));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Advance one edge; outputs are then sampled 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic w, input logic r, input logic [W-1:0] d);
      we      = w;
      re      = r;
      data_in = d;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_cnt"},   32'(s_cnt),   0);
      chk({tag, "_empty"}, 32'(s_empty), 1);
      chk({tag, "_full"},  32'(s_full),  0);
      chk({tag, "_ae"},    32'(s_ae),    1);
      chk({tag, "_af"},    32'(s_af),    0);
      chk({tag, "_ov"},    32'(s_ov),    0);
      chk({tag, "_un"},    32'(s_un),    0);
      chk({tag, "_dout"},  32'(s_dout),  0);
      chk({tag, "_fdout"}, 32'(f_dout),  0);
      chk({tag, "_fempty"},32'(f_empty), 1);
   endtask

   initial begin
      rst = 1'b0; clear = 1'b0;
      drive(0, 0, '0);
      step(); step();
      rst = 1'b1;
      chk_reset_state("rst");

      // Fill 8 words; almost_full from count 4.
      for (int i = 1; i <= 8; i++) begin
         drive(1, 0, W'(i));
         step();
         chk($sformatf("fill_cnt%0d", i), 32'(s_cnt), i);
         chk($sformatf("fill_af%0d", i), 32'(s_af), (i >= 4) ? 1 : 0);
         chk($sformatf("fill_ae%0d", i), 32'(s_ae), (i <= 4) ? 1 : 0);
      end
      chk("fill_full", 32'(s_full), 1);
      chk("fill_fwft_head", 32'(f_dout), 1);
      chk("fill_dout_held", 32'(s_dout), 0);
      drive(1, 0, 16'h0009);
      step();
      chk("ovf_flag", 32'(s_ov), 1);
      chk("ovf_cnt", 32'(s_cnt), 8);

      // Read back with registered output.
      for (int i = 1; i <= 8; i++) begin
         drive(0, 1, '0);
         step();
         chk($sformatf("rd_dout%0d", i), 32'(s_dout), i);
      end
      chk("rd_empty", 32'(s_empty), 1);
      chk("rd_un_before", 32'(s_un), 0);
      step();
      chk("udf_flag", 32'(s_un), 1);
      chk("udf_dout_held", 32'(s_dout), 8);
      chk("udf_ov_sticky", 32'(s_ov), 1);

      // Clear flushes sticky flags and holds data_out.
      drive(0, 0, '0);
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("clr_ov", 32'(s_ov), 0);
      chk("clr_un", 32'(s_un), 0);
      chk("clr_dout_held", 32'(s_dout), 8);

      // Interleaved traffic: 20 writes / 20 reads, pointers wrap twice.
      for (int i = 0; i < 20; i++) begin
         logic w, r;
         if (i < 3)       begin w = 1; r = 0; end
         else if (i < 6)  begin w = 1; r = 1; end
         else if (i < 9)  begin w = 1; r = 0; end
         else if (i < 20) begin w = 1; r = 1; end
         else             begin w = 0; r = 0; end
         drive(w, r, W'(16'h0100 + i));
         sb.push_back(W'(16'h0100 + i));
         step();
         if (r) begin
            exp_w = sb.pop_front();
            chk($sformatf("il_dout%0d", i), 32'(s_dout), 32'(exp_w));
         end
      end
      chk("il_cnt6", 32'(s_cnt), 6);
      for (int i = 0; i < 6; i++) begin
         drive(0, 1, '0);
         step();
         exp_w = sb.pop_front();
         chk($sformatf("il_drain%0d", i), 32'(s_dout), 32'(exp_w));
      end
      chk("il_empty", 32'(s_empty), 1);

      // Full with simultaneous write and read.
      for (int i = 0; i < 8; i++) begin
         drive(1, 0, W'(16'h0010 + i));
         step();
      end
      chk("fr_full", 32'(s_full), 1);
      drive(1, 1, 16'hAAAA);
      step();
      chk("fr_cnt", 32'(s_cnt), 8);
      chk("fr_ov", 32'(s_ov), 0);
      chk("fr_dout", 32'(s_dout), 16'h0010);
      for (int i = 1; i <= 8; i++) begin
         drive(0, 1, '0);
         step();
         chk($sformatf("fr_rd%0d", i), 32'(s_dout), (i < 8) ? 32'(16'h0010 + i) : 32'h0000AAAA);
      end
      chk("fr_empty", 32'(s_empty), 1);

      // FWFT: written word appears without a read.
      drive(1, 0, 16'h1234);
      step();
      drive(0, 0, '0);
      chk("fw_dout", 32'(f_dout), 16'h1234);
      chk("fw_empty", 32'(f_empty), 0);
      step();
      chk("fw_dout_stable", 32'(f_dout), 16'h1234);
      drive(0, 1, '0);
      step();
      chk("fw_rd_dout", 32'(f_dout), 0);
      chk("fw_rd_empty", 32'(f_empty), 1);
      chk("fw_std_dout", 32'(s_dout), 16'h1234);
      step();
      chk("fw_un", 32'(f_un), 1);

      // Clear at count 5 with a write pending.
      for (int i = 0; i < 5; i++) begin
         drive(1, 0, W'(16'h0050 + i));
         step();
      end
      chk("cl_cnt5", 32'(s_cnt), 5);
      drive(1, 0, 16'h0055);
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("cl_cnt", 32'(s_cnt), 0);
      chk("cl_empty", 32'(s_empty), 1);
      chk("cl_un", 32'(s_un), 0);
      chk("cl_fun", 32'(f_un), 0);
      chk("cl_ov", 32'(s_ov), 0);

      // Reset mid-stream overrides we/re.
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, W'(16'h0070 + i));
         step();
      end
      chk("mr_cnt3", 32'(s_cnt), 3);
      drive(1, 1, 16'h0077);
      rst = 1'b0;
      step();
      chk_reset_state("mrst");
      rst = 1'b1;
      drive(0, 0, '0);
      step();
      chk("post_rst_cnt", 32'(s_cnt), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
